mix_matrix: RTL and testbench

- Sits between adat_in and adat_out in the mixer top, in the oversampling_bitclock domain.
- Consumes one 8-channel input frame per adat_in data_valid pulse and computes an 8x8 gain matrix, out[o] = sum over i of in[i]*coef[o][i].
- Uses one time-shared multiplier.
- Presents a saturated 8-channel output frame for the adat_out audio bus; the CDC to adat_bitclock is outside this block.

---
 rtl/mixer_pkg.sv | 22 ++
 rtl/sat_shift.sv | 24 ++
 rtl/mix_matrix.sv | 138 +++++++++++++
 tb/tb_mix_matrix.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// Shared constants and types for the mixer datapath (adat_in, mix_matrix, adat_out).
package mixer_pkg;
  localparam int unsigned CH       = 8;
  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned COEF_W   = 18;
  localparam int unsigned FRAC     = 16;
  localparam int unsigned PROD_W   = SAMPLE_W + COEF_W;
  localparam int unsigned ACC_W    = SAMPLE_W + COEF_W + $clog2(CH);
  localparam int unsigned CH_W     = $clog2(CH);
  localparam int unsigned IDX_W    = 2 * CH_W;
  localparam int unsigned NCOEF    = CH * CH;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0]   coef_t;
  typedef logic signed [PROD_W-1:0]   prod_t;
  typedef logic signed [ACC_W-1:0]    acc_t;
  typedef logic [CH-1:0][SAMPLE_W-1:0] frame_t;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, PUBLISH} state_t;

  localparam coef_t COEF_ONE = coef_t'(1 << FRAC);
endpackage

// File: rtl/sat_shift.sv
// Rescales a Q.FRAC accumulator to a sample: floor shift, clamp to SAMPLE_W, flag clipping.
module sat_shift
  import mixer_pkg::*;
(
  input  acc_t    i_acc,
  output sample_t o_sample_c,
  output logic    o_clip_c
);
  localparam int unsigned TOP = FRAC + SAMPLE_W - 1;

  logic [ACC_W-1-TOP:0] w_hi;

  assign w_hi = i_acc[ACC_W-1:TOP];

  // Result fits only if every bit above the sample's sign bit matches it.
  always_comb begin
    o_clip_c   = !((&w_hi) || !(|w_hi));
    o_sample_c = i_acc[TOP:FRAC];
    if (o_clip_c) begin
      o_sample_c = i_acc[ACC_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                  : {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
  end
endmodule

// File: rtl/mix_matrix.sv
// 8x8 gain matrix with one time-shared multiplier; publishes a saturated frame
// 66 cycles after each accepted input frame.
module mix_matrix
  import mixer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  frame_t           in_audio,
  input  logic             coef_we,
  input  logic [IDX_W-1:0] coef_addr,
  input  coef_t            coef_data,
  output logic             coef_ready,
  output frame_t           out_audio,
  output logic             out_valid,
  output logic [CH-1:0]    clip,
  output logic             overrun
);
  state_t           r_state, w_next;
  logic [IDX_W-1:0] r_idx, r_pidx;
  logic             r_pvld;
  logic             r_ready;
  frame_t           r_shadow;
  coef_t            r_coef [NCOEF];
  prod_t            r_prod;
  acc_t             r_acc, w_acc_next;
  frame_t           r_back, w_pub_audio;
  logic [CH-1:0]    r_bclip, w_pub_clip;
  frame_t           r_out_audio;
  logic             r_out_valid;
  logic [CH-1:0]    r_clip;
  logic             r_overrun;
  sample_t          w_in_smp, w_sat;
  coef_t            w_coef;
  logic             w_clip;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = MAC;
      MAC:     if (r_idx == IDX_W'(NCOEF - 1)) w_next = DRAIN;
      DRAIN:   w_next = PUBLISH;
      PUBLISH: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_ready   <= 1'b1;
      r_idx     <= '0;
      r_pidx    <= '0;
      r_pvld    <= 1'b0;
      r_shadow  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ready   <= (w_next == IDLE);
      r_pidx    <= r_idx;
      r_pvld    <= (r_state == MAC);
      r_overrun <= in_valid && (r_state != IDLE);
      if (r_state == IDLE && in_valid) begin
        r_shadow <= in_audio;
        r_idx    <= '0;
      end else if (r_state == MAC) begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  // Coefficient RAM, reset to identity; writes only land while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NCOEF; k++) begin
        r_coef[IDX_W'(k)] <= ((k / CH) == (k % CH)) ? COEF_ONE : '0;
      end
    end else if (coef_we && r_ready) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  assign w_in_smp   = sample_t'(r_shadow[r_idx[CH_W-1:0]]);
  assign w_coef     = r_coef[r_idx];
  assign w_acc_next = ((r_pidx[CH_W-1:0] == '0) ? acc_t'(0) : r_acc) + acc_t'(r_prod);

  sat_shift u_sat (
    .i_acc      (w_acc_next),
    .o_sample_c (w_sat),
    .o_clip_c   (w_clip)
  );

  // Output 7 completes in DRAIN, so it bypasses the back buffer on publish.
  always_comb begin
    w_pub_audio         = r_back;
    w_pub_clip          = r_bclip;
    w_pub_audio[CH-1]   = w_sat;
    w_pub_clip[CH-1]    = w_clip;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prod  <= '0;
      r_acc   <= '0;
      r_back  <= '0;
      r_bclip <= '0;
    end else begin
      if (r_state == MAC) r_prod <= prod_t'(w_in_smp) * prod_t'(w_coef);
      if (r_pvld) begin
        r_acc <= w_acc_next;
        if (r_pidx[CH_W-1:0] == CH_W'(CH - 1)) begin
          r_back[r_pidx[IDX_W-1:CH_W]]  <= w_sat;
          r_bclip[r_pidx[IDX_W-1:CH_W]] <= w_clip;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_audio <= '0;
      r_out_valid <= 1'b0;
      r_clip      <= '0;
    end else begin
      r_out_valid <= (r_state == DRAIN);
      if (r_state == DRAIN) begin
        r_out_audio <= w_pub_audio;
        r_clip      <= w_pub_clip;
      end
    end
  end

  assign coef_ready = r_ready;
  assign out_audio  = r_out_audio;
  assign out_valid  = r_out_valid;
  assign clip       = r_clip;
  assign overrun    = r_overrun;
endmodule

// File: tb/tb_mix_matrix.sv
// Scoreboard bench for mix_matrix: stimulus pushes expected frames, a monitor pops on out_valid.
module tb_mix_matrix;
  import mixer_pkg::*;

  logic             clk;
  logic             rst;
  logic             in_valid;
  frame_t           in_audio;
  logic             coef_we;
  logic [IDX_W-1:0] coef_addr;
  coef_t            coef_data;
  logic             coef_ready;
  frame_t           out_audio;
  logic             out_valid;
  logic [CH-1:0]    clip;
  logic             overrun;

  typedef struct {
    frame_t        audio;
    logic [CH-1:0] clip;
    int            due;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   ovr_cnt  = 0;

  mix_matrix dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_audio   (in_audio),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_ready (coef_ready),
    .out_audio  (out_audio),
    .out_valid  (out_valid),
    .clip       (clip),
    .overrun    (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic frame_t fr(input int a0, a1, a2, a3, a4, a5, a6, a7);
    frame_t f;
    f[0] = SAMPLE_W'(a0); f[1] = SAMPLE_W'(a1); f[2] = SAMPLE_W'(a2); f[3] = SAMPLE_W'(a3);
    f[4] = SAMPLE_W'(a4); f[5] = SAMPLE_W'(a5); f[6] = SAMPLE_W'(a6); f[7] = SAMPLE_W'(a7);
    return f;
  endfunction

  // Monitor: pops one expected frame per out_valid; also counts overrun pulses.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (overrun === 1'b1) ovr_cnt++;
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d, required no frame", cyc);
        end else begin
          e = q.pop_front();
          check("latency_cycle", cyc, e.due);
          for (int k = 0; k < CH; k++)
            check($sformatf("out_audio[%0d]", k), $signed(out_audio[k]), $signed(e.audio[k]));
          check("clip", clip, e.clip);
        end
      end
    end
  end

  task automatic send(input frame_t f, input frame_t ef, input logic [CH-1:0] ec, output int c);
    exp_t e;
    @(negedge clk);
    c        = cyc;
    in_valid = 1'b1;
    in_audio = f;
    e.audio  = ef;
    e.clip   = ec;
    e.due    = c + 66;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_in(input frame_t f);
    in_valid = 1'b1;
    in_audio = f;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic write_coef(input int o, input int i, input int val);
    int n;
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = IDX_W'(o * CH + i);
    coef_data = coef_t'(val);
    n = 0;
    while (!coef_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!coef_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL coef_write_timeout: coef_ready=0 after %0d cycles, required 1", n);
    end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d frames outstanding, required 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int c;
    int n;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_audio  = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < CH; k++) check($sformatf("rst_out_audio[%0d]", k), $signed(out_audio[k]), 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_clip", clip, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_coef_ready", coef_ready, 1);

    // Identity passthrough after reset
    send(fr(100, -200, 300, -400, 500, -600, 700, -800),
         fr(100, -200, 300, -400, 500, -600, 700, -800), 8'h00, c);
    wait_drain();

    // Half/half mix into output 0
    write_coef(0, 0, 32768);
    write_coef(0, 1, 32768);
    send(fr(1000, 3000, -7, 8, -9, 10, 11, -12),
         fr(2000, 3000, -7, 8, -9, 10, 11, -12), 8'h00, c);
    wait_drain();

    // Positive saturation on output 0
    for (int k = 0; k < CH; k++) write_coef(0, k, 65536);
    send(fr(8388607, 8388607, 8388607, 8388607, 8388607, 8388607, 8388607, 8388607),
         fr(8388607, 8388607, 8388607, 8388607, 8388607, 8388607, 8388607, 8388607), 8'h01, c);
    wait_drain();

    // Floor rounding on output 1
    write_coef(1, 1, 32768);
    send(fr(10, -3, 20, 30, -40, 50, 60, -70),
         fr(57, -2, 20, 30, -40, 50, 60, -70), 8'h00, c);
    wait_drain();

    // Negative saturation on output 0
    send(fr(-8388608, -8388608, -8388608, -8388608, -8388608, -8388608, -8388608, -8388608),
         fr(-8388608, -4194304, -8388608, -8388608, -8388608, -8388608, -8388608, -8388608), 8'h01, c);
    wait_drain();

    // Overrun during MAC
    send(fr(1, 2, 3, 4, 5, 6, 7, 8), fr(36, 1, 3, 4, 5, 6, 7, 8), 8'h00, c);
    wait_cyc(c + 10);
    pulse_in(fr(999, 999, 999, 999, 999, 999, 999, 999));
    wait_drain();
    check("overrun_count_mac", ovr_cnt, 1);

    // in_valid in the PUBLISH cycle is also dropped
    send(fr(1, 2, 3, 4, 5, 6, 7, 8), fr(36, 1, 3, 4, 5, 6, 7, 8), 8'h00, c);
    wait_cyc(c + 66);
    pulse_in(fr(-5, -5, -5, -5, -5, -5, -5, -5));
    wait_drain();
    check("overrun_count_publish", ovr_cnt, 2);

    // Coefficient write held during a busy frame
    send(fr(1, 2, 3, 4, 5, 6, 7, 8), fr(36, 1, 3, 4, 5, 6, 7, 8), 8'h00, c);
    repeat (5) @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = IDX_W'(2 * CH + 2);
    coef_data = coef_t'(-65536);
    check("coef_ready_busy", coef_ready, 0);
    n = 0;
    while (!coef_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("coef_ready_rise_cycle", cyc, c + 67);
    @(negedge clk);
    coef_we = 1'b0;
    wait_drain();
    send(fr(1, 2, 3, 4, 5, 6, 7, 8), fr(36, 1, -3, 4, 5, 6, 7, 8), 8'h00, c);
    wait_drain();

    // Reset mid-frame aborts it and restores identity coefficients
    send(fr(9, 9, 9, 9, 9, 9, 9, 9), fr(72, 4, -9, 9, 9, 9, 9, 9), 8'h00, c);
    wait_cyc(c + 30);
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    for (int k = 0; k < CH; k++) check($sformatf("midrst_out_audio[%0d]", k), $signed(out_audio[k]), 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_clip", clip, 0);
    rst = 1'b1;
    repeat (80) @(negedge clk);
    send(fr(11, -22, 33, -44, 55, -66, 77, -88),
         fr(11, -22, 33, -44, 55, -66, 77, -88), 8'h00, c);
    wait_drain();
    check("final_overrun_count", ovr_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
